// File: rtl/div_iter_pkg.sv
// ---------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the iterative divider: the controller state encoding
// and the func3 operation codes presented on div_ctrl.
// ---------------------------------------------------------------------------
package div_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

endpackage

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative restoring divider for DIV/DIVU/REM/REMU. One quotient bit is
// produced per clock. Divide-by-zero and signed overflow bypass the loop.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request an operation (accepted only in IDLE with a div func3)
//   kill      : abort any operation in flight; wins over start
//   op1, op2  : dividend, divisor
//   div_ctrl  : func3 (100 DIV, 101 DIVU, 110 REM, 111 REMU)
//   busy      : operation accepted and not yet completed
//   done      : one-cycle result-valid pulse
//   result    : quotient or remainder, held after done
// ---------------------------------------------------------------------------
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [2:0]            div_ctrl,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        return ~x + 1'b1;
    endfunction

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          rem_sel_q;   // 1: return remainder, 0: quotient
    logic          q_neg_q;     // quotient needs negation in FIX
    logic          r_neg_q;     // remainder needs negation in FIX
    logic [W-1:0]  dvs_q;       // divisor magnitude
    logic [W-1:0]  quo_q;       // dividend shifts out, quotient shifts in
    logic [W-1:0]  rem_q;       // partial remainder
    logic [W-1:0]  result_q;

    logic          accept, signed_op, a_neg, b_neg, div_zero, overflow;
    logic signed [W-1:0] op1_s, op2_s;
    logic [W-1:0]  a_mag, b_mag, sel_val;
    logic [W:0]    rem_sh, dvs_ext;
    logic          ge;

    // ---- operand decode at accept ----
    assign accept    = (state_q == IDLE) && start && div_ctrl[2] && !kill;
    assign signed_op = (div_ctrl == DIV) || (div_ctrl == REM);
    assign op1_s     = op1;
    assign op2_s     = op2;
    assign a_neg     = signed_op && (op1_s < 0);
    assign b_neg     = signed_op && (op2_s < 0);
    assign a_mag     = a_neg ? negate(op1) : op1;
    assign b_mag     = b_neg ? negate(op2) : op2;
    assign div_zero  = (op2 == '0);
    assign overflow  = signed_op && (op1 == MIN_INT) && (op2 == '1);

    // ---- one restoring step: the shifted remainder needs W+1 bits ----
    assign rem_sh  = {rem_q, quo_q[W-1]};
    assign dvs_ext = {1'b0, dvs_q};
    assign ge      = (rem_sh >= dvs_ext);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (div_zero || overflow) ? DONE : CALC;
            CALC: if (cnt_q == CW'(W-1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    // Outputs: result tracks the selected value only while done is asserted,
    // so a killed DONE cycle leaves the visible result untouched.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE) && !kill;
        sel_val = rem_sel_q ? rem_q : quo_q;
        result  = done ? sel_val : result_q;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        rem_sel_q <= div_ctrl[1];
                        dvs_q     <= b_mag;
                        if (div_zero) begin
                            quo_q   <= '1;
                            rem_q   <= op1;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                        end else if (overflow) begin
                            quo_q   <= MIN_INT;
                            rem_q   <= '0;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    quo_q <= {quo_q[W-2:0], ge};
                    rem_q <= ge ? W'(rem_sh - dvs_ext) : rem_sh[W-1:0];
                end
                FIX: begin
                    if (q_neg_q) quo_q <= negate(quo_q);
                    if (r_neg_q) rem_q <= negate(rem_q);
                end
                DONE: begin
                    if (!kill) result_q <= sel_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter
// Directed testbench for div_iter (DATA_WIDTH = 32).
// ---------------------------------------------------------------------------
module tb_div_iter;
    import div_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  div_ctrl;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    div_iter #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kill     (kill),
        .op1      (op1),
        .op2      (op2),
        .div_ctrl (div_ctrl),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Issues one operation, measures
    // the accept-to-done latency, checks busy throughout and the result, then
    // returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat,
                          input bit poke);
        int lat;
        int busy_bad;
        op1 = a; op2 = b; div_ctrl = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_bad++;
            if (poke && lat == 5) begin
                op1 = 32'd0; op2 = 32'd0; div_ctrl = DIVU; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"},       32'(lat), 32'(exp_lat));
        check({tag, "_busy_run"},  32'(busy_bad), 32'd0);
        check({tag, "_res"},       result, exp);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"},  32'(busy), 32'd0);
        check({tag, "_held"},       result, exp);
    endtask

    initial begin : stim
        int lat;
        int done_seen;
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        op1 = '0; op2 = '0; div_ctrl = 3'b000;
        #12;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start with a non-divide func3 is ignored
        op1 = 32'd10; op2 = 32'd2; div_ctrl = 3'b000; start = 1'b1;
        @(negedge clk);
        check("nondiv_ignored", 32'(busy), 32'd0);
        // kill together with start in IDLE: no accept
        div_ctrl = DIVU; kill = 1'b1;
        @(negedge clk);
        check("kill_start_idle", 32'(busy), 32'd0);
        start = 1'b0; kill = 1'b0;
        @(negedge clk);

        // main function; the first one also pokes start while busy
        run_op("div_100_7",   DIV,  32'd100,        32'd7,        32'd14,         34, 1'b1);
        run_op("rem_m100_7",  REM,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE,   34, 1'b0);
        run_op("div_m100_7",  DIV,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,   34, 1'b0);
        run_op("div_7_m2",    DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   34, 1'b0);
        run_op("rem_7_m2",    REM,  32'd7,          32'hFFFFFFFE, 32'd1,          34, 1'b0);
        run_op("divu_big",    DIVU, 32'hFFFFFFFF,   32'h80000000, 32'd1,          34, 1'b0);
        run_op("remu_big",    REMU, 32'hFFFFFFFF,   32'h80000000, 32'h7FFFFFFF,   34, 1'b0);
        run_op("div_zero",    DIV,  32'd5,          32'd0,        32'hFFFFFFFF,   1,  1'b0);
        run_op("rem_zero",    REM,  32'd5,          32'd0,        32'd5,          1,  1'b0);
        run_op("div_ovf",     DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000,   1,  1'b0);
        run_op("rem_ovf",     REM,  32'h80000000,   32'hFFFFFFFF, 32'd0,          1,  1'b0);
        run_op("divu_ff_2",   DIVU, 32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF,   34, 1'b0);
        run_op("remu_ff_2",   REMU, 32'hFFFFFFFF,   32'd2,        32'd1,          34, 1'b0);

        // kill at CALC cycle 10, then an immediate new start
        op1 = 32'd1000; op2 = 32'd3; div_ctrl = DIVU; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_seen = 0;
        for (lat = 1; lat < 10; lat++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy",      32'(busy), 32'd0);
        check("kill_done",      32'(done), 32'd0);
        check("kill_no_done",   32'(done_seen), 32'd0);
        check("kill_result",    result, 32'd1);
        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b0);

        // asynchronous reset in the middle of an operation
        op1 = 32'd77; op2 = 32'd5; div_ctrl = DIV; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy), 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("arst_no_done", 32'(done_seen), 32'd0);
        run_op("div_after_rst", DIV, 32'd100, 32'd7, 32'd14, 34, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound so the bench can never hang.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
